ppu_spr_dma: RTL and testbench
==============================

Name: ppu_spr_dma

Overview:
- Sprite DMA initiator: the bus-master counterpart of the PPU register interface.
- A CPU write to 0x4014 latches a source page. The block then halts the CPU and drives the CPU memory bus itself.
- It alternates reads of {page,idx} with writes of that byte to 0x2004 (sprite RAM data port), for 256 bytes.
- It sits beside the CPU core on the CPU memory bus and is muxed in while active_out is high.

Parameters:
TRIGGER_ADDR, 16'h4014, CPU write address that starts a transfer
DEST_ADDR, 16'h2004, PPU register address written for each byte

Ports:
clk_in  input  1  50MHz system clock
rst_in  input  1  reset, asynchronous, active-high
cyc_en_in  input  1  one-clk pulse per CPU cycle; all state advances only when high
cpumc_a_in  input  16  CPU core address bus (trigger decode)
cpumc_r_nw_in  input  1  CPU core read/write select (1=read)
cpumc_din_in  input  8  CPU memory bus read data; also CPU write data for the trigger
active_out  output  1  DMA owns the bus; CPU must be held (rdy low) and its bus outputs muxed out
cpumc_a_out  output  16  DMA bus address
cpumc_r_nw_out  output  1  DMA bus read/write select
cpumc_d_out  output  8  DMA bus write data

Behaviour:
- Reset (async, immediate): state=IDLE, page=0, idx=0, data latch=0, active_out=0, cpumc_a_out=0, cpumc_r_nw_out=1, cpumc_d_out=0. Reset mid-transfer aborts it; no partial resume.
- State machine: IDLE, ALIGN, READ, WRITE. Every transition and every latch below occurs only on a posedge with cyc_en_in=1.
- IDLE: outputs hold their reset values.
  - Trigger when cpumc_a_in==TRIGGER_ADDR and cpumc_r_nw_in=0.
  - On trigger: page<=cpumc_din_in, idx<=0, go to ALIGN.
  - Reads of TRIGGER_ADDR do not trigger.
- ALIGN: active_out=1, cpumc_a_out=0, cpumc_r_nw_out=1. This is one dummy CPU cycle for the CPU halt, then go to READ.
- READ: active_out=1, cpumc_a_out={page,idx}, cpumc_r_nw_out=1, cpumc_d_out=0. At cycle end, data<=cpumc_din_in, then go to WRITE.
- WRITE: active_out=1, cpumc_a_out=DEST_ADDR, cpumc_r_nw_out=0, cpumc_d_out=data. At cycle end:
  - if idx==8'hFF: go to IDLE, idx<=0;
  - else: idx<=idx+1 (8-bit), go to READ.
- Total transfer length: exactly 513 cyc_en_in pulses from the trigger pulse to active_out falling, i.e. 1 ALIGN + 256×(READ+WRITE).
- active_out rises on the clk after the trigger pulse and falls on the clk of the final WRITE's cyc_en_in.
- Consecutive WRITEs are separated by a READ of a different address. The decoded PPU /CS therefore deasserts between writes, so each 0x2004 write presents a fresh falling edge to the PPU.
- Triggers seen while not IDLE are ignored. The CPU is halted, so any such bus activity is the DMA's own.
- cyc_en_in low: all state and outputs hold, with no limit on gap length.
- idx wraps only at 0xFF→0x00 on completion. Page is not incremented, and the source never crosses a page boundary.
- Page 0x20–0x3F is legal; those reads hit PPU registers with their normal side effects.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

Test Plan:
- Memory page 0x02 holds byte[i]=i^8'hA5. CPU writes 0x02 to 0x4014 with cyc_en_in every 24 clks.
  -> active_out rises 1 clk after the trigger pulse.
  -> Bus shows ALIGN, then {0x0200 rd, 0x2004 wr 0xA5}, {0x0201 rd, 0x2004 wr 0xA4} … {0x02FF rd, 0x2004 wr 0x5A}.
  -> active_out falls on the 513th pulse. Sprite RAM contents match.
- Random cyc_en_in gaps of 0–50 clks -> identical bus sequence. No state or output changes on clks with cyc_en_in=0.
- CPU read of 0x4014, and write of 0x4015 -> no trigger; active_out stays 0 and outputs stay at reset values.
- Trigger with page 0x03. Mid-transfer (idx=0x40), the bench drives cpumc_a_in=0x4014, r_nw=0, data 0x07.
  -> Ignored: remaining reads stay on page 0x03 and the count is unchanged.
- Assert rst_in asynchronously (not clock-aligned) during WRITE at idx=100.
  -> active_out=0, cpumc_r_nw_out=1, cpumc_a_out=0, cpumc_d_out=0 before the next clk edge.
  -> A new trigger (page 0x05) starts at 0x0500 with a full 513-cycle transfer.
- Back-to-back triggers (second trigger 1 CPU cycle after completion, page 0x06) -> second transfer runs in full. No residual idx or data from the first.

Source files
------------

// File: rtl/ppu_spr_dma_if.sv
// CPU memory bus seen by the sprite DMA: the CPU core's trigger-side signals in,
// the DMA's own bus drive out.
interface ppu_spr_dma_if;
  logic        cyc_en_in;
  logic [15:0] cpumc_a_in;
  logic        cpumc_r_nw_in;
  logic [7:0]  cpumc_din_in;
  logic        active_out;
  logic [15:0] cpumc_a_out;
  logic        cpumc_r_nw_out;
  logic [7:0]  cpumc_d_out;

  modport master (
    input  cyc_en_in, cpumc_a_in, cpumc_r_nw_in, cpumc_din_in,
    output active_out, cpumc_a_out, cpumc_r_nw_out, cpumc_d_out
  );

  modport slave (
    output cyc_en_in, cpumc_a_in, cpumc_r_nw_in, cpumc_din_in,
    input  active_out, cpumc_a_out, cpumc_r_nw_out, cpumc_d_out
  );
endinterface

// File: rtl/ppu_spr_dma.sv
// Sprite DMA: a write to TRIGGER_ADDR copies 256 bytes of the written page to DEST_ADDR,
// alternating a read and a write per byte while holding the CPU off the bus.
module ppu_spr_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
  input logic           clk_in,
  input logic           rst_in,
  ppu_spr_dma_if.master bus
);

  typedef enum logic [1:0] {StIdle, StAlign, StRead, StWrite} state_e;

  state_e      state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  data_q;
  logic        active_q;
  logic [15:0] addr_q;
  logic        r_nw_q;
  logic [7:0]  dout_q;

  // Bus outputs are loaded together with the state they belong to, so they come
  // straight from flops and never see the inputs combinationally.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      data_q   <= 8'h00;
      active_q <= 1'b0;
      addr_q   <= 16'h0000;
      r_nw_q   <= 1'b1;
      dout_q   <= 8'h00;
    end else if (bus.cyc_en_in) begin
      unique case (state_q)
        StIdle: begin
          if (bus.cpumc_a_in == TRIGGER_ADDR && !bus.cpumc_r_nw_in) begin
            state_q  <= StAlign;
            page_q   <= bus.cpumc_din_in;
            idx_q    <= 8'h00;
            active_q <= 1'b1;
            addr_q   <= 16'h0000;
            r_nw_q   <= 1'b1;
            dout_q   <= 8'h00;
          end
        end
        StAlign: begin
          state_q <= StRead;
          addr_q  <= {page_q, idx_q};
          r_nw_q  <= 1'b1;
          dout_q  <= 8'h00;
        end
        StRead: begin
          state_q <= StWrite;
          data_q  <= bus.cpumc_din_in;
          addr_q  <= DEST_ADDR;
          r_nw_q  <= 1'b0;
          dout_q  <= bus.cpumc_din_in;
        end
        StWrite: begin
          if (idx_q == 8'hFF) begin
            state_q  <= StIdle;
            idx_q    <= 8'h00;
            active_q <= 1'b0;
            addr_q   <= 16'h0000;
            r_nw_q   <= 1'b1;
            dout_q   <= 8'h00;
          end else begin
            state_q <= StRead;
            idx_q   <= idx_q + 8'd1;
            addr_q  <= {page_q, idx_q + 8'd1};
            r_nw_q  <= 1'b1;
            dout_q  <= 8'h00;
          end
        end
      endcase
    end
  end

  assign bus.active_out     = active_q;
  assign bus.cpumc_a_out    = addr_q;
  assign bus.cpumc_r_nw_out = r_nw_q;
  assign bus.cpumc_d_out    = dout_q;

endmodule

// File: tb/tb_ppu_spr_dma.sv
// Randomised bench for ppu_spr_dma: expected bus cycles are queued per trigger and a
// negedge monitor pops and compares them, with a sprite-RAM model checked after each copy.
module tb_ppu_spr_dma;

  typedef struct packed {
    logic [15:0] a;
    logic        rnw;
    logic [7:0]  d;
  } xact_t;

  localparam xact_t IdleX = '{a: 16'h0000, rnw: 1'b1, d: 8'h00};
  localparam int    Xfer  = 513;

  logic clk_in = 1'b0;
  logic rst_in;
  always #10 clk_in = ~clk_in;

  ppu_spr_dma_if bus ();

  ppu_spr_dma dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] spr [0:255];
  logic [7:0] oam_ptr;
  logic [7:0] cpu_d;
  xact_t      exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         gap_min = 23;
  int         gap_max = 23;

  // Memory answers DMA reads; otherwise the bus carries the CPU's write data.
  assign bus.cpumc_din_in = (bus.active_out && bus.cpumc_r_nw_out) ? mem[bus.cpumc_a_out] : cpu_d;

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // cyc_en generator with a programmable gap between pulses
  initial begin
    int cnt = 0;
    bus.cyc_en_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #2;
      if (cnt == 0) begin
        bus.cyc_en_in = 1'b1;
        cnt = int'($urandom_range(gap_max, gap_min));
      end else begin
        bus.cyc_en_in = 1'b0;
        cnt--;
      end
    end
  end

  // Monitor: compares each enabled bus cycle against the scoreboard and checks
  // that nothing moves across clocks without a cyc_en pulse.
  initial begin
    xact_t cur, snap, e;
    bit    prev_cyc = 1'b1;
    bit    prev_act = 1'b0;
    snap = IdleX;
    forever begin
      @(negedge clk_in);
      cur = '{a: bus.cpumc_a_out, rnw: bus.cpumc_r_nw_out, d: bus.cpumc_d_out};
      if (rst_in) begin
        prev_cyc = 1'b1;
        continue;
      end
      if (!prev_cyc)
        check("hold_without_cyc_en", cur == snap && bus.active_out == prev_act,
              32'({bus.active_out, cur}), 32'({prev_act, snap}));
      if (bus.cyc_en_in) begin
        if (bus.active_out) begin
          if (exp_q.size() == 0) begin
            check("extra_bus_cycle", 1'b0, 32'(cur), 32'(IdleX));
          end else begin
            e = exp_q.pop_front();
            check("bus_cycle", cur == e, 32'(cur), 32'(e));
            if (!cur.rnw && cur.a == 16'h2004) begin
              spr[oam_ptr] = cur.d;
              oam_ptr++;
            end
          end
        end else begin
          check("idle_bus", cur == IdleX && exp_q.size() == 0, 32'(cur), 32'(IdleX));
        end
      end
      snap     = cur;
      prev_act = bus.active_out;
      prev_cyc = bus.cyc_en_in;
    end
  end

  task automatic cpu_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    @(negedge clk_in);
    bus.cpumc_a_in    = a;
    bus.cpumc_r_nw_in = rnw;
    cpu_d             = d;
    do @(posedge clk_in); while (!bus.cyc_en_in);
    #1;
    bus.cpumc_a_in    = 16'h8000;
    bus.cpumc_r_nw_in = 1'b1;
    cpu_d             = 8'h00;
  endtask

  // Reference: ALIGN, then read page:i / write 0x2004 with that byte, for all 256 bytes.
  task automatic trigger(input logic [7:0] page);
    cpu_cycle(16'h4014, 1'b0, page);
    check("active_rise", bus.active_out == 1'b1, 32'(bus.active_out), 32'd1);
    oam_ptr = 8'h00;
    exp_q.push_back(IdleX);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{a: {page, 8'(i)}, rnw: 1'b1, d: 8'h00});
      exp_q.push_back('{a: 16'h2004, rnw: 1'b0, d: mem[{page, 8'(i)}]});
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.active_out) && n < 40000) begin
      @(negedge clk_in);
      n++;
    end
    check(name, n < 40000, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_remaining(input int left);
    int n = 0;
    while (exp_q.size() > left && n < 40000) begin
      @(negedge clk_in);
      n++;
    end
    check("reach_point", n < 40000, 32'(exp_q.size()), 32'(left));
  endtask

  task automatic check_spr(input logic [7:0] page);
    for (int i = 0; i < 256; i++)
      check("sprite_ram", spr[i] == mem[{page, 8'(i)}], 32'(spr[i]), 32'(mem[{page, 8'(i)}]));
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    xact_t cur;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 256; i++) spr[i] = 8'h00;
    oam_ptr           = 8'h00;
    cpu_d             = 8'h00;
    bus.cpumc_a_in    = 16'h8000;
    bus.cpumc_r_nw_in = 1'b1;
    rst_in            = 1'b1;
    repeat (3) @(posedge clk_in);
    #3;
    cur = '{a: bus.cpumc_a_out, rnw: bus.cpumc_r_nw_out, d: bus.cpumc_d_out};
    check("reset_state", cur == IdleX && !bus.active_out, 32'({bus.active_out, cur}),
          32'(IdleX));
    @(negedge clk_in);
    rst_in = 1'b0;

    // Page 0x02, cyc_en every 24 clocks
    trigger(8'h02);
    wait_done("done_page02_fixed");
    check_spr(8'h02);

    // Same copy with random 0-50 clock gaps
    gap_min = 0;
    gap_max = 50;
    trigger(8'h02);
    wait_done("done_page02_random");
    check_spr(8'h02);

    // Non-triggering accesses
    gap_max = 3;
    cpu_cycle(16'h4014, 1'b1, 8'h02);
    cpu_cycle(16'h4015, 1'b0, 8'h02);
    repeat (10) @(negedge clk_in);
    check("no_trigger", bus.active_out == 1'b0, 32'(bus.active_out), 32'd0);

    // Trigger attempt in the middle of a transfer must be ignored
    trigger(8'h03);
    wait_remaining(Xfer - 1 - 2 * 8'h40);
    repeat (3) cpu_cycle(16'h4014, 1'b0, 8'h07);
    wait_done("done_page03_retrigger");
    check_spr(8'h03);

    // Asynchronous reset in the WRITE of byte 100, then a clean restart
    gap_min = 23;
    gap_max = 23;
    trigger(8'h04);
    wait_remaining(Xfer - 1 - 201);
    @(posedge clk_in);
    #3;
    check("in_write_100", bus.active_out && bus.cpumc_a_out == 16'h2004 && !bus.cpumc_r_nw_out,
          32'(bus.cpumc_a_out), 32'h2004);
    rst_in = 1'b1;
    #1;
    cur = '{a: bus.cpumc_a_out, rnw: bus.cpumc_r_nw_out, d: bus.cpumc_d_out};
    check("async_reset", cur == IdleX && !bus.active_out, 32'({bus.active_out, cur}),
          32'(IdleX));
    exp_q.delete();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    gap_min = 0;
    gap_max = 5;
    trigger(8'h05);
    wait_done("done_page05_after_reset");
    check_spr(8'h05);

    // Back-to-back transfers on consecutive CPU cycles
    gap_min = 0;
    gap_max = 0;
    trigger(8'h01);
    wait_done("done_page01");
    trigger(8'h06);
    wait_done("done_page06_back_to_back");
    check_spr(8'h06);

    repeat (4) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
